// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, byte-wide write and read paths and no clock stretching.
// The optional glitch filter on SCL/SDA is enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       wr_data,
  input  logic [7:0] data_in,
  output logic       rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6,
    WAIT_STOP = 3'd7
  } state_e;

  state_e     r_state, w_nextState;
  logic [1:0] r_sclSync, r_sdaSync;
  logic       r_sclDly, r_sdaDly;
  logic [2:0] r_settle;
  logic [7:0] r_shift;
  logic [2:0] r_bitCnt;
  logic       r_byteDone;
  logic       w_scl, w_sda, w_live;
  logic       w_sclRise, w_sclFall, w_start, w_stop, w_addrMatch;
  logic       w_sdaOeNext, w_wrPulse, w_rdPulse, w_busyNext;

  // Two-flop synchronizers; they reset to the idle-bus level (both lines high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
    end else begin
      r_sclSync <= {r_sclSync[0], scl_in};
      r_sdaSync <= {r_sdaSync[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_sclHist, r_sdaHist;
  logic       r_sclFilt, r_sdaFilt;

  // Filtered level follows a line only once three consecutive samples agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclHist <= 2'b11;
      r_sdaHist <= 2'b11;
      r_sclFilt <= 1'b1;
      r_sdaFilt <= 1'b1;
    end else begin
      r_sclHist <= {r_sclHist[0], r_sclSync[1]};
      r_sdaHist <= {r_sdaHist[0], r_sdaSync[1]};
      if (r_sclHist == {2{r_sclSync[1]}}) r_sclFilt <= r_sclSync[1];
      if (r_sdaHist == {2{r_sdaSync[1]}}) r_sdaFilt <= r_sdaSync[1];
    end
  end

  assign w_scl = r_sclFilt;
  assign w_sda = r_sdaFilt;
`else
  assign w_scl = r_sclSync[1];
  assign w_sda = r_sdaSync[1];
`endif

  // One-clk delay of the line levels for edge detection, plus a settle counter that
  // masks detection until the pipeline holds real pad levels after reset; otherwise a
  // low SDA seen after a mid-transfer reset release would look like a START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclDly <= 1'b1;
      r_sdaDly <= 1'b1;
      r_settle <= 3'd0;
    end else begin
      r_sclDly <= w_scl;
      r_sdaDly <= w_sda;
      if (!w_live) r_settle <= r_settle + 3'd1;
    end
  end

  assign w_live      = &r_settle;
  assign w_sclRise   = w_live & w_scl & ~r_sclDly;
  assign w_sclFall   = w_live & ~w_scl & r_sclDly;
  assign w_start     = w_live & w_scl & r_sclDly & r_sdaDly & ~w_sda;
  assign w_stop      = w_live & w_scl & r_sclDly & ~r_sdaDly & w_sda;
  assign w_addrMatch = (r_shift[7:1] == SLAVE_ADDR);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; STOP and START override every state. A master NACK leaves
  // READ_ACK on the rising edge, so a falling edge still in READ_ACK means ACK.
  always_comb begin
    w_nextState = r_state;
    if (w_stop) begin
      w_nextState = IDLE;
    end else if (w_start) begin
      w_nextState = ADDR;
    end else begin
      case (r_state)
        ADDR:      if (w_sclFall && r_byteDone) w_nextState = w_addrMatch ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (w_sclFall) w_nextState = r_shift[0] ? READ : WRITE;
        WRITE:     if (w_sclFall && r_byteDone) w_nextState = WRITE_ACK;
        WRITE_ACK: if (w_sclFall) w_nextState = WRITE;
        READ:      if (w_sclFall && r_byteDone) w_nextState = READ_ACK;
        READ_ACK: begin
          if (w_sclRise && w_sda) w_nextState = WAIT_STOP;
          else if (w_sclFall)     w_nextState = READ;
        end
        default: ;
      endcase
    end
  end

  // Output decode: next SDA drive, strobes and busy, all changing on SCL falling
  // edges except busy dropping at a master NACK.
  always_comb begin
    w_sdaOeNext = sda_oe;
    w_wrPulse   = 1'b0;
    w_rdPulse   = 1'b0;
    w_busyNext  = busy;
    if (w_stop) begin
      w_sdaOeNext = 1'b0;
      w_busyNext  = 1'b0;
    end else if (w_start) begin
      w_sdaOeNext = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_sclFall && r_byteDone) begin
            w_sdaOeNext = w_addrMatch;
            w_busyNext  = w_addrMatch;
          end
        end
        ADDR_ACK: begin
          if (w_sclFall) begin
            w_rdPulse   = r_shift[0];
            w_sdaOeNext = r_shift[0] ? ~data_in[7] : 1'b0;
          end
        end
        WRITE: begin
          if (w_sclFall && r_byteDone) begin
            w_wrPulse   = 1'b1;
            w_sdaOeNext = 1'b1;
          end
        end
        WRITE_ACK: if (w_sclFall) w_sdaOeNext = 1'b0;
        READ:      if (w_sclFall) w_sdaOeNext = r_byteDone ? 1'b0 : ~r_shift[6];
        READ_ACK: begin
          if (w_sclRise && w_sda) begin
            w_busyNext = 1'b0;
          end else if (w_sclFall) begin
            w_rdPulse   = 1'b1;
            w_sdaOeNext = ~data_in[7];
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs so the pad enable and strobes are glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_oe   <= 1'b0;
      wr_data  <= 1'b0;
      rd_data  <= 1'b0;
      busy     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      sda_oe  <= w_sdaOeNext;
      wr_data <= w_wrPulse;
      rd_data <= w_rdPulse;
      busy    <= w_busyNext;
      if (w_wrPulse) data_out <= r_shift;
    end
  end

  // Shift register and bit counter: shift in on SCL rise for address/write bytes,
  // shift out on SCL fall for read bytes, and flag a full byte after the 8th rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_byteDone <= 1'b0;
    end else if (w_start || w_stop) begin
      r_bitCnt   <= 3'd0;
      r_byteDone <= 1'b0;
    end else begin
      case (r_state)
        ADDR, WRITE: begin
          if (w_sclRise) begin
            r_shift  <= {r_shift[6:0], w_sda};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_byteDone <= 1'b1;
          end else if (w_sclFall && r_byteDone) begin
            r_byteDone <= 1'b0;
          end
        end
        READ: begin
          if (w_sclRise) begin
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_byteDone <= 1'b1;
          end else if (w_sclFall) begin
            if (r_byteDone) r_byteDone <= 1'b0;
            else            r_shift    <= {r_shift[6:0], 1'b0};
          end
        end
        ADDR_ACK: if (w_sclFall && r_shift[0]) r_shift <= data_in;
        READ_ACK: if (w_sclFall) r_shift <= data_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bus master model drives SCL/SDA over a
// wired-AND SDA line, and expected bytes are queued and compared as the DUT delivers them.
module tb_i2c_slave;

  localparam int Q = 10;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       masterScl = 1'b1;
  logic       masterSda = 1'b1;
  logic       glitchLow = 1'b0;
  logic [7:0] data_in   = 8'h00;
  logic       sdaBus;
  logic       sda_oe, wr_data, rd_data, busy;
  logic [7:0] data_out;

  int         checkCount   = 0;
  int         errorCount   = 0;
  int         wrPulseCount = 0;
  int         rdPulseCount = 0;
  logic       oeSeen       = 1'b0;
  logic       busySeen     = 1'b0;
  logic [7:0] wrExpQ[$];
  logic [7:0] rdExpQ[$];

  assign sdaBus = masterSda & ~sda_oe & ~glitchLow;

  always #10 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (masterScl),
    .sda_in   (sdaBus),
    .sda_oe   (sda_oe),
    .data_out (data_out),
    .wr_data  (wr_data),
    .data_in  (data_in),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Count a comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive both master line levels and hold them for a number of clocks.
  task automatic applyStimulus(input logic scl, input logic sda, input int clks);
    masterScl = scl;
    masterSda = sda;
    waitClks(clks);
  endtask

  task automatic clockBit(input logic b, output logic sampled);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, Q);
    sampled = sdaBus;
    applyStimulus(1'b1, b, Q);
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic busStart();
    if (masterScl == 1'b0) begin
      applyStimulus(1'b0, 1'b1, Q);
      applyStimulus(1'b1, 1'b1, Q);
    end
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic busStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(d[i], s);
    clockBit(1'b1, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clockBit(1'b1, s);
      d = {d[6:0], s};
    end
    clockBit(nack, s);
  endtask

  // Watch strobes and drive activity; each write strobe pops the next expected byte.
  always @(negedge clk) begin
    if (sda_oe) oeSeen = 1'b1;
    if (busy) busySeen = 1'b1;
    if (rd_data) rdPulseCount++;
    if (wr_data) begin
      wrPulseCount++;
      if (wrExpQ.size() == 0) checkOutput("wr_unexpected", 1, 0);
      else checkOutput("wr_data_out", {24'h0, data_out}, {24'h0, wrExpQ.pop_front()});
    end
  end

  // Bound the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rxByte;
    int         wrBase, rdBase;
    logic [7:0] rstByte;

    // Reset state
    waitClks(3);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_data_out", data_out, 0);
    reset = 1'b1;
    waitClks(20);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-clk SDA low with SCL high must not be taken as START.
    glitchLow = 1'b1;
    waitClks(1);
    glitchLow = 1'b0;
    waitClks(10);
    checkOutput("glitch_state_idle", int'(dut.r_state), 0);
`endif

    // Write 0xA5, 0x3C to matching address
    wrBase = wrPulseCount;
    busStart();
    writeByte(8'hA0, ack);
    checkOutput("wr_addr_ack", ack, 1);
    checkOutput("wr_busy_high", busy, 1);
    wrExpQ.push_back(8'hA5);
    writeByte(8'hA5, ack);
    checkOutput("wr_byte1_ack", ack, 1);
    wrExpQ.push_back(8'h3C);
    writeByte(8'h3C, ack);
    checkOutput("wr_byte2_ack", ack, 1);
    checkOutput("wr_busy_before_stop", busy, 1);
    busStop();
    checkOutput("wr_busy_after_stop", busy, 0);
    checkOutput("wr_pulse_count", wrPulseCount - wrBase, 2);
    waitClks(20);

    // Non-matching address 0x51: no drive, no strobe, never busy
    wrBase   = wrPulseCount;
    oeSeen   = 1'b0;
    busySeen = 1'b0;
    busStart();
    writeByte(8'hA2, ack);
    checkOutput("mis_addr_nack", ack, 0);
    writeByte(8'h77, ack);
    checkOutput("mis_byte_nack", ack, 0);
    busStop();
    checkOutput("mis_oe_never", oeSeen, 0);
    checkOutput("mis_busy_never", busySeen, 0);
    checkOutput("mis_no_wr", wrPulseCount - wrBase, 0);
    waitClks(20);

    // Read 0xC3 (master ACK) then 0x81 (master NACK)
    rdBase  = rdPulseCount;
    data_in = 8'hC3;
    rdExpQ.push_back(8'hC3);
    busStart();
    writeByte(8'hA1, ack);
    checkOutput("rd_addr_ack", ack, 1);
    data_in = 8'h81;
    rdExpQ.push_back(8'h81);
    readByte(1'b0, rxByte);
    checkOutput("rd_byte1", rxByte, rdExpQ.pop_front());
    readByte(1'b1, rxByte);
    checkOutput("rd_byte2", rxByte, rdExpQ.pop_front());
    checkOutput("rd_state_wait_stop", int'(dut.r_state), 7);
    checkOutput("rd_sda_oe_released", sda_oe, 0);
    checkOutput("rd_busy_after_nack", busy, 0);
    checkOutput("rd_pulse_count", rdPulseCount - rdBase, 2);
    busStop();
    waitClks(20);

    // Write 0x10, repeated START, then read
    wrBase = wrPulseCount;
    rdBase = rdPulseCount;
    busStart();
    writeByte(8'hA0, ack);
    checkOutput("rs_wr_addr_ack", ack, 1);
    wrExpQ.push_back(8'h10);
    writeByte(8'h10, ack);
    checkOutput("rs_wr_byte_ack", ack, 1);
    data_in = 8'h5A;
    rdExpQ.push_back(8'h5A);
    busStart();
    checkOutput("rs_state_addr", int'(dut.r_state), 1);
    writeByte(8'hA1, ack);
    checkOutput("rs_rd_addr_ack", ack, 1);
    checkOutput("rs_first_rd_pulse", rdPulseCount - rdBase, 1);
    readByte(1'b1, rxByte);
    checkOutput("rs_rd_byte", rxByte, rdExpQ.pop_front());
    busStop();
    checkOutput("rs_wr_count", wrPulseCount - wrBase, 1);
    waitClks(20);

    // Reset during the 5th bit of a write byte
    rstByte = 8'h96;
    busStart();
    writeByte(8'hA0, ack);
    checkOutput("rst_mid_addr_ack", ack, 1);
    for (int i = 7; i >= 4; i--) clockBit(rstByte[i], s);
    applyStimulus(1'b0, rstByte[3], Q);
    applyStimulus(1'b1, rstByte[3], Q / 2);
    #3 reset = 1'b0;
    #1;
    checkOutput("rst_async_sda_oe", sda_oe, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_wr_data", wr_data, 0);
    checkOutput("rst_async_rd_data", rd_data, 0);
    checkOutput("rst_async_data_out", data_out, 0);
    waitClks(4);
    reset    = 1'b1;
    oeSeen   = 1'b0;
    busySeen = 1'b0;
    applyStimulus(1'b1, rstByte[3], Q);
    applyStimulus(1'b0, rstByte[3], Q);
    for (int i = 2; i >= 0; i--) clockBit(rstByte[i], s);
    clockBit(1'b1, s);
    checkOutput("rst_mid_no_ack", s, 1);
    busStop();
    checkOutput("rst_mid_oe_never", oeSeen, 0);
    checkOutput("rst_mid_busy_never", busySeen, 0);
    waitClks(20);

    // Fresh transaction after reset is acknowledged again
    busStart();
    writeByte(8'hA0, ack);
    checkOutput("post_rst_addr_ack", ack, 1);
    wrExpQ.push_back(8'h42);
    writeByte(8'h42, ack);
    checkOutput("post_rst_byte_ack", ack, 1);
    busStop();
    waitClks(20);

    checkOutput("wr_queue_empty", wrExpQ.size(), 0);
    checkOutput("rd_queue_empty", rdExpQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
